// File: rtl/ram_1p_adv_if.sv
// rtl/ram_1p_adv_if.sv - request/response bundle between a table controller and ram_1p_adv
interface ram_1p_adv_if #(
    parameter int Depth = 128,
    parameter int Width = 32
);
    localparam int Aw = $clog2(Depth);

    logic             req_i;
    logic             write_i;
    logic [Aw-1:0]    addr_i;
    logic [Width-1:0] wdata_i;
    logic [Width-1:0] wmask_i;
    logic [9:0]       cfg_i;
    logic [Width-1:0] rdata_o;
    logic             rvalid_o;
    logic [1:0]       rerror_o;

    modport master (
        output req_i, write_i, addr_i, wdata_i, wmask_i, cfg_i,
        input  rdata_o, rvalid_o, rerror_o
    );

    modport slave (
        input  req_i, write_i, addr_i, wdata_i, wmask_i, cfg_i,
        output rdata_o, rvalid_o, rerror_o
    );
endinterface

// File: rtl/ram_1p_adv.sv
// rtl/ram_1p_adv.sv - single-port RAM with grouped write mask, read strobe and byte parity
module ram_1p_adv #(
    parameter int Depth                = 128,
    parameter int Width                = 32,
    parameter int DataBitsPerMask      = 1,
    parameter int EnableParity         = 0,
    parameter int EnableInputPipeline  = 0,
    parameter int EnableOutputPipeline = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    ram_1p_adv_if.slave bus
);
    localparam int Aw        = $clog2(Depth);
    localparam int NumGroups = Width / DataBitsPerMask;
    localparam int NumBytes  = (Width >= 8) ? Width / 8 : 1;
    localparam logic [Aw:0] DepthW = (Aw + 1)'(Depth);

    logic             w_req;
    logic             w_write;
    logic [Aw-1:0]    w_addr;
    logic [Width-1:0] w_wdata;
    logic [Width-1:0] w_wmask;
    logic [9:0]       w_unused_cfg;

    assign w_unused_cfg = bus.cfg_i;

    generate
        if (EnableInputPipeline != 0) begin : g_in_pipe
            logic             r_req;
            logic             r_write;
            logic [Aw-1:0]    r_addr;
            logic [Width-1:0] r_wdata;
            logic [Width-1:0] r_wmask;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_req   <= 1'b0;
                    r_write <= 1'b0;
                    r_addr  <= '0;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end else begin
                    r_req   <= bus.req_i;
                    r_write <= bus.write_i;
                    r_addr  <= bus.addr_i;
                    r_wdata <= bus.wdata_i;
                    r_wmask <= bus.wmask_i;
                end
            end

            assign w_req   = r_req;
            assign w_write = r_write;
            assign w_addr  = r_addr;
            assign w_wdata = r_wdata;
            assign w_wmask = r_wmask;
        end else begin : g_in_direct
            assign w_req   = bus.req_i;
            assign w_write = bus.write_i;
            assign w_addr  = bus.addr_i;
            assign w_wdata = bus.wdata_i;
            assign w_wmask = bus.wmask_i;
        end
    endgenerate

    logic             w_in_range;
    logic             w_we;
    logic             w_re;
    logic             w_perr;
    logic [Width-1:0] w_bmask;
    logic [Width-1:0] w_rdata;

    // Upper addresses exist only when Depth is not a power of two; writes there are dropped.
    assign w_in_range = ({1'b0, w_addr} < DepthW);
    assign w_we       = w_req & w_write & w_in_range;
    assign w_re       = w_req & ~w_write;

    // A mask group takes effect only when every bit of the group is enabled.
    always_comb begin
        w_bmask = '0;
        for (int g = 0; g < NumGroups; g++) begin
            w_bmask[g*DataBitsPerMask +: DataBitsPerMask] =
                {DataBitsPerMask{&w_wmask[g*DataBitsPerMask +: DataBitsPerMask]}};
        end
    end

    logic [Width-1:0] r_mem [Depth];

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int i = 0; i < Width; i++) begin
                if (w_bmask[i]) r_mem[w_addr][i] <= w_wdata[i];
            end
        end
    end

    assign w_rdata = r_mem[w_addr];

    generate
        if (EnableParity != 0) begin : g_parity
            logic [NumBytes-1:0] r_par [Depth];
            logic [NumBytes-1:0] w_wpar;
            logic [NumBytes-1:0] w_pen;
            logic [NumBytes-1:0] w_rbad;

            always_comb begin
                w_wpar = '0;
                w_pen  = '0;
                w_rbad = '0;
                for (int b = 0; b < NumBytes; b++) begin
                    w_wpar[b] = ^w_wdata[b*8 +: 8];
                    w_pen[b]  = &w_bmask[b*8 +: 8];
                    w_rbad[b] = ^{w_rdata[b*8 +: 8], r_par[w_addr][b]};
                end
            end

            always_ff @(posedge clk_i) begin
                if (w_we) begin
                    for (int b = 0; b < NumBytes; b++) begin
                        if (w_pen[b]) r_par[w_addr][b] <= w_wpar[b];
                    end
                end
            end

            assign w_perr = |w_rbad;
        end else begin : g_no_parity
            assign w_perr = 1'b0;
        end
    endgenerate

    logic             r_a_valid;
    logic [Width-1:0] r_a_data;
    logic             r_a_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_a_err   <= 1'b0;
        end else begin
            r_a_valid <= w_re;
            r_a_err   <= w_re & w_in_range & w_perr;
            if (w_re) r_a_data <= w_in_range ? w_rdata : '0;
        end
    end

    logic             w_o_valid;
    logic [Width-1:0] w_o_data;
    logic             w_o_err;

    generate
        if (EnableOutputPipeline != 0) begin : g_out_pipe
            logic             r_o_valid;
            logic [Width-1:0] r_o_data;
            logic             r_o_err;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_o_valid <= 1'b0;
                    r_o_data  <= '0;
                    r_o_err   <= 1'b0;
                end else begin
                    r_o_valid <= r_a_valid;
                    r_o_err   <= r_a_err;
                    if (r_a_valid) r_o_data <= r_a_data;
                end
            end

            assign w_o_valid = r_o_valid;
            assign w_o_data  = r_o_data;
            assign w_o_err   = r_o_err;
        end else begin : g_out_direct
            assign w_o_valid = r_a_valid;
            assign w_o_data  = r_a_data;
            assign w_o_err   = r_a_err;
        end
    endgenerate

    assign bus.rvalid_o = w_o_valid;
    assign bus.rdata_o  = w_o_data;
    assign bus.rerror_o = {w_o_err, 1'b0};
endmodule

// File: tb/tb_ram_1p_adv.sv
// tb/tb_ram_1p_adv.sv - randomized model-checked bench: 64-bit flat RAM and 32-bit parity/pipelined RAM
module tb_ram_1p_adv;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_1p_adv_if #(.Depth(128), .Width(64)) ifa ();
    ram_1p_adv_if #(.Depth(100), .Width(32)) ifb ();

    ram_1p_adv #(
        .Depth(128), .Width(64), .DataBitsPerMask(32), .EnableParity(0),
        .EnableInputPipeline(0), .EnableOutputPipeline(0)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa)
    );

    ram_1p_adv #(
        .Depth(100), .Width(32), .DataBitsPerMask(8), .EnableParity(1),
        .EnableInputPipeline(1), .EnableOutputPipeline(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb)
    );

    typedef struct {
        bit          req;
        bit          wr;
        int          addr;
        logic [63:0] wdata;
        logic [63:0] wmask;
    } op_t;

    typedef struct {
        int          due;
        logic [63:0] d;
        logic [1:0]  e;
    } exp_t;

    logic [63:0] mem_a [128];
    logic [31:0] mem_b [100];
    logic [3:0]  cor_b [100];
    exp_t        qa [$];
    exp_t        qb [$];
    logic [63:0] last_a;
    logic [63:0] last_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk(bit req, bit wr, int addr, logic [63:0] d, logic [63:0] m);
        op_t o;
        o.req = req; o.wr = wr; o.addr = addr; o.wdata = d; o.wmask = m;
        return o;
    endfunction

    function automatic logic [63:0] rnd_mask(int groups, int gw);
        logic [63:0] m;
        m = '0;
        for (int g = 0; g < groups; g++) begin
            case ($urandom_range(0, 2))
                0: m = m | (((64'd1 << gw) - 64'd1) << (g * gw));
                1: m = m;
                default: m = m | ((64'($urandom) & ((64'd1 << gw) - 64'd1)) << (g * gw));
            endcase
        end
        return m;
    endfunction

    task automatic check_outputs();
        exp_t e;
        if (qa.size() != 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            chk("a_rvalid", 64'(ifa.rvalid_o), 64'd1);
            chk("a_rdata", ifa.rdata_o, e.d);
            chk("a_rerror", 64'(ifa.rerror_o), 64'(e.e));
            last_a = e.d;
        end else begin
            chk("a_rvalid_idle", 64'(ifa.rvalid_o), 64'd0);
            chk("a_rdata_hold", ifa.rdata_o, last_a);
            chk("a_rerror_idle", 64'(ifa.rerror_o), 64'd0);
        end
        if (qb.size() != 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            chk("b_rvalid", 64'(ifb.rvalid_o), 64'd1);
            chk("b_rdata", 64'(ifb.rdata_o), e.d);
            chk("b_rerror", 64'(ifb.rerror_o), 64'(e.e));
            last_b = e.d;
        end else begin
            chk("b_rvalid_idle", 64'(ifb.rvalid_o), 64'd0);
            chk("b_rdata_hold", 64'(ifb.rdata_o), last_b);
            chk("b_rerror_idle", 64'(ifb.rerror_o), 64'd0);
        end
    endtask

    task automatic step(input op_t oa, input op_t ob);
        exp_t e;
        bit   in_b;
        ifa.req_i   = oa.req;
        ifa.write_i = oa.wr;
        ifa.addr_i  = 7'(oa.addr);
        ifa.wdata_i = oa.wdata;
        ifa.wmask_i = oa.wmask;
        ifa.cfg_i   = 10'($urandom);
        ifb.req_i   = ob.req;
        ifb.write_i = ob.wr;
        ifb.addr_i  = 7'(ob.addr);
        ifb.wdata_i = ob.wdata[31:0];
        ifb.wmask_i = ob.wmask[31:0];
        ifb.cfg_i   = 10'($urandom);

        if (oa.req && oa.wr) begin
            for (int h = 0; h < 2; h++)
                if (oa.wmask[h*32 +: 32] == 32'hFFFF_FFFF)
                    mem_a[oa.addr][h*32 +: 32] = oa.wdata[h*32 +: 32];
        end else if (oa.req) begin
            e.due = cyc + 1; e.d = mem_a[oa.addr]; e.e = 2'b00;
            qa.push_back(e);
        end

        in_b = (ob.addr < 100);
        if (ob.req && ob.wr) begin
            if (in_b)
                for (int b = 0; b < 4; b++)
                    if (ob.wmask[b*8 +: 8] == 8'hFF) begin
                        mem_b[ob.addr][b*8 +: 8] = ob.wdata[b*8 +: 8];
                        cor_b[ob.addr][b] = 1'b0;
                    end
        end else if (ob.req) begin
            e.due = cyc + 3;
            e.d   = in_b ? {32'h0, mem_b[ob.addr]} : 64'h0;
            e.e   = (in_b && cor_b[ob.addr] != 4'h0) ? 2'b10 : 2'b00;
            qb.push_back(e);
        end

        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    op_t idle;
    op_t ra;
    op_t rb;

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        last_a = '0; last_b = '0;
        for (int i = 0; i < 100; i++) cor_b[i] = 4'h0;
        idle = mk(0, 0, 0, 64'h0, 64'h0);
        ifa.req_i = 0; ifa.write_i = 0; ifa.addr_i = '0; ifa.wdata_i = '0; ifa.wmask_i = '0; ifa.cfg_i = '0;
        ifb.req_i = 0; ifb.write_i = 0; ifb.addr_i = '0; ifb.wdata_i = '0; ifb.wmask_i = '0; ifb.cfg_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_rvalid", 64'(ifa.rvalid_o), 64'd0);
        chk("rst_a_rdata", ifa.rdata_o, 64'd0);
        chk("rst_a_rerror", 64'(ifa.rerror_o), 64'd0);
        chk("rst_b_rvalid", 64'(ifb.rvalid_o), 64'd0);
        chk("rst_b_rdata", 64'(ifb.rdata_o), 64'd0);
        chk("rst_b_rerror", 64'(ifb.rerror_o), 64'd0);
        rst_n = 1'b1;

        // Fill every location so later reads are defined; B writes at 100..127 must be dropped.
        for (int i = 0; i < 128; i++)
            step(mk(1, 1, i, {$urandom, $urandom}, '1), mk(1, 1, i, 64'($urandom), '1));

        step(mk(1, 1, 5, 64'h0123_4567_89AB_CDEF, '1), idle);
        step(mk(1, 0, 5, 64'h0, 64'h0), mk(1, 0, 5, 64'h0, 64'h0));
        chk("a_full_write", ifa.rdata_o, 64'h0123_4567_89AB_CDEF);
        step(mk(1, 1, 5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000), idle);
        step(mk(1, 0, 5, 64'h0, 64'h0), idle);
        chk("a_masked_write", ifa.rdata_o, 64'hFFFF_FFFF_89AB_CDEF);
        step(mk(1, 1, 3, 64'hAAAA_0000_1111_2222, '1), mk(1, 1, 3, 64'h1357_9BDF, '1));
        step(mk(1, 0, 3, 64'h0, 64'h0), mk(1, 0, 3, 64'h0, 64'h0));
        step(mk(1, 1, 3, 64'hBBBB_3333_4444_5555, '1), mk(1, 1, 3, 64'h2468_ACE0, '1));
        step(mk(1, 0, 3, 64'h0, 64'h0), mk(1, 0, 3, 64'h0, 64'h0));
        chk("a_b2b_second", ifa.rdata_o, 64'hBBBB_3333_4444_5555);
        step(idle, mk(1, 1, 110, 64'hDEAD_BEEF, '1));
        step(idle, mk(1, 0, 110, 64'h0, 64'h0));
        step(idle, mk(1, 1, 9, 64'h00C0_FFEE, 64'h0000_FF00));
        step(idle, mk(1, 0, 9, 64'h0, 64'h0));
        repeat (3) step(idle, idle);
        chk("b_b2b_second", 64'(ifb.rdata_o), {32'h0, mem_b[9]});

        dut_b.r_mem[7][3] = ~dut_b.r_mem[7][3];
        mem_b[7][3] = ~mem_b[7][3];
        cor_b[7][0] = ~cor_b[7][0];
        step(idle, mk(1, 0, 7, 64'h0, 64'h0));
        step(idle, mk(1, 0, 8, 64'h0, 64'h0));
        step(idle, idle);
        chk("b_parity_err", 64'(ifb.rerror_o), 64'h2);
        step(idle, idle);
        chk("b_parity_clean", 64'(ifb.rerror_o), 64'h0);
        step(idle, mk(1, 1, 7, 64'h0000_005A, 64'h0000_00FF));
        step(idle, mk(1, 0, 7, 64'h0, 64'h0));
        repeat (3) step(idle, idle);

        for (int n = 0; n < 400; n++) begin
            ra = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 127),
                    {$urandom, $urandom}, rnd_mask(2, 32));
            rb = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 127),
                    64'($urandom), rnd_mask(4, 8));
            step(ra, rb);
        end
        repeat (3) step(idle, idle);

        step(mk(1, 1, 5, 64'h0F0F_0F0F_F0F0_F0F0, '1), mk(1, 1, 5, 64'hCAFE_F00D, '1));
        step(mk(1, 0, 5, 64'h0, 64'h0), mk(1, 0, 5, 64'h0, 64'h0));
        rst_n = 1'b0;
        #1;
        chk("midrst_b_rvalid", 64'(ifb.rvalid_o), 64'd0);
        chk("midrst_b_rdata", 64'(ifb.rdata_o), 64'd0);
        chk("midrst_a_rdata", ifa.rdata_o, 64'd0);
        qb.delete();
        last_a = '0;
        last_b = '0;
        repeat (4) step(idle, idle);
        rst_n = 1'b1;
        step(mk(1, 0, 5, 64'h0, 64'h0), mk(1, 0, 5, 64'h0, 64'h0));
        chk("postrst_a_addr5", ifa.rdata_o, 64'h0F0F_0F0F_F0F0_F0F0);
        repeat (2) step(idle, idle);
        chk("postrst_b_addr5", 64'(ifb.rdata_o), 64'hCAFE_F00D);
        repeat (2) step(idle, idle);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
